mux_nto1_stream: RTL
====================

// Module: mux_nto1_stream
// PURPOSE
//   Parametrised N:1 channel multiplexer with valid/ready handshake and a registered output.
//   It replaces the fixed 4:1 combinational bit mux on the scheduler datapath.
//   Selection is latched and held for a whole transaction, so beats from different
//   channels never interleave. It sits between the per-core request queues and the
//   single shared memory-port interface.
// PARAMETERS
//   N_CH      4   number of input channels (>=2)
//   DATA_W    16  data width per channel
//   LOCK_MODE 1   1: hold selection until s_last beat; 0: release after every beat
//   SEL_W     derived $clog2(N_CH), localparam, not overridable
// PORTS
//   clk        in   1              clock, all logic rising-edge
//   rst        in   1              asynchronous, active-high reset
//   s_data     in   N_CH*DATA_W    channel data, ch i at [i*DATA_W +: DATA_W]
//   s_valid    in   N_CH           per-channel beat valid
//   s_last     in   N_CH           per-channel last beat of transaction
//   s_ready    out  N_CH           per-channel ready
//   sel        in   SEL_W          requested channel
//   sel_valid  in   1              sel request strobe
//   m_data     out  DATA_W         registered output data
//   m_valid    out  1              output valid
//   m_last     out  1              output last
//   m_ready    in   1              downstream ready
//   busy       out  1              1 while in LOCKED
//   cur_sel    out  SEL_W          latched channel
//   err_sel    out  1              one-cycle pulse: sel_valid with sel >= N_CH
// BEHAVIOUR
//   Reset (async assert, sync deassert by design above):
//     state=IDLE; m_valid/m_last/busy/err_sel=0; m_data=0; cur_sel=0; s_ready=0.
//   FSM IDLE:
//     s_ready all 0.
//     sel_valid && sel<N_CH: cur_sel<=sel, go LOCKED next cycle.
//     sel_valid && sel>=N_CH: err_sel=1 next cycle, stay IDLE.
//   FSM LOCKED:
//     busy=1.
//     s_ready[cur_sel] = !m_valid || m_ready. All other s_ready bits = 0 (combinational).
//     sel/sel_valid are ignored; err_sel is never raised in LOCKED.
//   Transfer:
//     s_valid[cur_sel] && s_ready[cur_sel] loads m_data/m_last; m_valid=1 next cycle.
//     Latency is 1 cycle.
//     m_valid && m_ready with no new transfer clears m_valid. m_data holds its last value.
//     Simultaneous output drain and input load: m_valid stays 1, no bubble.
//     Full rate is 1 beat/cycle while m_ready=1.
//   Release:
//     LOCK_MODE=1: the transfer carrying s_last returns to IDLE next cycle.
//     LOCK_MODE=0: every transfer returns to IDLE.
//     The registered beat still drains normally after release.
//     A new sel_valid accepted in IDLE costs a 1-cycle bubble, minimum.
//   Stall:
//     m_valid && !m_ready holds m_data/m_last stable, and s_ready[cur_sel]=0.
//   Reset mid-transaction:
//     The output beat is dropped; the FSM goes to IDLE. Upstream must restart the transaction.
//   Only cur_sel affects the output; s_valid on unselected channels has no effect.
// TESTING
//   1 Reset:
//     assert rst mid-LOCKED with m_valid=1 -> all outputs 0 that cycle, state IDLE.
//   2 4-beat packet:
//     sel=2, sel_valid; ch2 sends 0xA1..0xA4, last on 0xA4, m_ready=1
//     -> m_data A1..A4 on consecutive cycles; busy drops the cycle after the A4 load.
//   3 Backpressure:
//     m_ready=0 for 3 cycles mid-packet -> m_data stable; s_ready[2]=0; no beat lost or duplicated.
//   4 Lock hold:
//     sel changed to 1 during ch2 packet -> ignored; ch1 s_ready stays 0; cur_sel=2 until release.
//   5 Bad select:
//     N_CH=3, sel=3, sel_valid -> err_sel 1-cycle pulse; busy stays 0.
//   6 LOCK_MODE=0:
//     ch0 two beats, no last -> only first beat passes; IDLE after it; re-select is needed.

Source files
------------

// File: rtl/mux_nto1_stream.sv
// N:1 stream multiplexer: selection is latched for a whole transaction, one registered
// output stage with valid/ready flow control at full rate.
module mux_nto1_stream #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned DATA_W    = 16,
  parameter bit          LOCK_MODE = 1'b1,
  localparam int unsigned SEL_W    = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*DATA_W-1:0]   s_data,
  input  logic [N_CH-1:0]          s_valid,
  input  logic [N_CH-1:0]          s_last,
  output logic [N_CH-1:0]          s_ready,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     sel_valid,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_valid,
  output logic                     m_last,
  input  logic                     m_ready,
  output logic                     busy,
  output logic [SEL_W-1:0]         cur_sel,
  output logic                     err_sel
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                sel_ok;
  logic                sel_load;
  logic                err_d;
  logic                can_take;
  logic                xfer;
  logic [DATA_W-1:0]   ch_data;
  logic                ch_valid;
  logic                ch_last;

  // A power-of-two channel count cannot encode an out-of-range select.
  if (N_CH == (2 ** SEL_W)) begin : g_sel_full
    assign sel_ok = 1'b1;
  end else begin : g_sel_partial
    assign sel_ok = (32'(sel) < N_CH);
  end

  // Pick the latched channel's beat.
  always_comb begin
    ch_data  = '0;
    ch_valid = 1'b0;
    ch_last  = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (cur_sel == SEL_W'(i)) begin
        ch_data  = s_data[i*DATA_W +: DATA_W];
        ch_valid = s_valid[i];
        ch_last  = s_last[i];
      end
    end
  end

  assign can_take = (state_q == LOCKED) && (!m_valid || m_ready);
  assign xfer     = can_take && ch_valid;

  always_comb begin
    s_ready = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      s_ready[i] = can_take && (cur_sel == SEL_W'(i));
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    sel_load = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          if (sel_ok) begin
            state_d  = LOCKED;
            sel_load = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (xfer && (!LOCK_MODE || ch_last)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      err_sel <= 1'b0;
      cur_sel <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == LOCKED);
      err_sel <= err_d;
      if (sel_load) begin
        cur_sel <= sel;
      end
    end
  end

  // Output register: a load and a drain in the same cycle keep m_valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else if (xfer) begin
      m_data  <= ch_data;
      m_valid <= 1'b1;
      m_last  <= ch_last;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule
